bcd_timer_ctrl: RTL and testbench

BCD_TIMER_CTRL -- requirements
Module: bcd_timer_ctrl

---
 rtl/bcd_timer_ctrl_pkg.sv | 19 +
 rtl/bcd_timer_ctrl_if.sv | 21 ++
 rtl/bcd_timer_ctrl_digit.sv | 31 +++
 rtl/bcd_timer_ctrl.sv | 154 +++++++++++++++
 tb/tb_bcd_timer_ctrl.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/bcd_timer_ctrl_pkg.sv
// Shared types and constants for the two-digit BCD down-counting timer.
package bcd_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int            BCD_W   = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    // True when both nibbles of a two-digit value are legal BCD digits.
    function automatic logic is_bcd(input logic [2*BCD_W-1:0] val);
        return (val[7:4] <= BCD_MAX) && (val[3:0] <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_timer_ctrl_if.sv
// Control/status bundle between the timer and its host.
interface bcd_timer_ctrl_if;
    logic       start;
    logic       stop;
    logic       load;
    logic [7:0] preset;
    logic [7:0] count;
    logic       running;
    logic       done;
    logic       err;

    modport master (
        output start, stop, load, preset,
        input  count, running, done, err
    );

    modport slave (
        input  start, stop, load, preset,
        output count, running, done, err
    );
endinterface

// File: rtl/bcd_timer_ctrl_digit.sv
// One BCD digit with load and borrow-chained decrement (9 after 0).
module bcd_digit_dn
    import bcd_timer_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [BCD_W-1:0] load_val_i,
    input  logic             dec_i,
    input  logic             borrow_i,
    output logic [BCD_W-1:0] digit_o,
    output logic             borrow_o
);

    logic [BCD_W-1:0] digit_q;

    assign digit_o  = digit_q;
    assign borrow_o = borrow_i && (digit_q == '0);

    // Digit register: load has precedence over decrement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q <= '0;
        end else if (load_i) begin
            digit_q <= load_val_i;
        end else if (dec_i && borrow_i) begin
            digit_q <= (digit_q == '0) ? BCD_MAX : digit_q - 1'b1;
        end
    end

endmodule

// File: rtl/bcd_timer_ctrl.sv
// Two-digit BCD down-counting timer with run/pause/done sequencing.
// Optional build macro BCD_TIMER_AUTO_RELOAD_EN: the zero-reaching tick
// reloads from the preset register and keeps running instead of stopping.
//
// state | meaning
// IDLE  | loaded or reset, waiting for start
// RUN   | prescaler active, count decrements once per TICK_DIV clocks
// PAUSE | stopped mid-run, count and preset held
// DONE  | count reached 00, start reloads from the preset register
module bcd_timer_ctrl
    import bcd_timer_pkg::*;
#(
    parameter int TICK_DIV = 4
) (
    input  logic               clk,
    input  logic               reset,
    bcd_timer_ctrl_if.slave    bus
);

    localparam logic [7:0] TDIV_M1 = 8'(TICK_DIV - 1);

    state_t     state_q, state_d;
    logic [7:0] preset_q, preset_d;
    logic [7:0] presc_q, presc_d;
    logic       running_q, running_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    logic       cnt_load;
    logic [7:0] cnt_load_val;
    logic       cnt_dec;
    logic [3:0] units, tens;
    logic       units_borrow;
    logic       tens_borrow;
    logic [7:0] count;
    logic       tick;

    assign count = {tens, units};
    assign tick  = (state_q == ST_RUN) && (presc_q == TDIV_M1);

    bcd_digit_dn u_units (
        .clk        (clk),
        .rst_n      (reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val[3:0]),
        .dec_i      (cnt_dec),
        .borrow_i   (1'b1),
        .digit_o    (units),
        .borrow_o   (units_borrow)
    );

    bcd_digit_dn u_tens (
        .clk        (clk),
        .rst_n      (reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val[7:4]),
        .dec_i      (cnt_dec),
        .borrow_i   (units_borrow),
        .digit_o    (tens),
        .borrow_o   (tens_borrow)
    );

    // Next-state decode; digit load/decrement strobes come from the same decision.
    always_comb begin
        state_d      = state_q;
        preset_d     = preset_q;
        presc_d      = presc_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = bus.preset;
        cnt_dec      = 1'b0;

        if (state_q == ST_RUN) begin
            if (bus.stop) begin
                // Stop wins over a coincident tick so the paused count is exact.
                state_d = ST_PAUSE;
            end else if (tick) begin
                presc_d = '0;
                if (count == 8'h01) begin
                    done_d = 1'b1;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
                    cnt_load     = 1'b1;
                    cnt_load_val = preset_q;
`else
                    cnt_dec = 1'b1;
                    state_d = ST_DONE;
`endif
                end else if (count != 8'h00) begin
                    cnt_dec = 1'b1;
                end
            end else begin
                presc_d = presc_q + 8'd1;
            end
        end else begin
            if (bus.load) begin
                if (is_bcd(bus.preset)) begin
                    cnt_load = 1'b1;
                    preset_d = bus.preset;
                    state_d  = ST_IDLE;
                end else begin
                    err_d = 1'b1;
                end
            end else if (bus.start) begin
                if (state_q == ST_DONE) begin
                    if (preset_q != 8'h00) begin
                        cnt_load     = 1'b1;
                        cnt_load_val = preset_q;
                        state_d      = ST_RUN;
                        presc_d      = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (count != 8'h00) begin
                    state_d = ST_RUN;
                    presc_d = '0;
                end else begin
                    err_d = 1'b1;
                end
            end
        end

        running_d = (state_d == ST_RUN);
    end

    // Control state and registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            preset_q  <= '0;
            presc_q   <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            preset_q  <= preset_d;
            presc_q   <= presc_d;
            running_q <= running_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign bus.count   = count;
    assign bus.running = running_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;

    // The tens borrow-out only matters for a decrement below 00, which never happens.
    logic unused_borrow;
    assign unused_borrow = tens_borrow;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Directed bench for bcd_timer_ctrl with TICK_DIV=2.
module tb_bcd_timer_ctrl;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    bcd_timer_ctrl_if bus ();

    bcd_timer_ctrl #(.TICK_DIV(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [7:0] seq12 [12] = '{8'h11, 8'h10, 8'h09, 8'h08, 8'h07, 8'h06,
                               8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};

    initial begin
        bus.start  = 1'b0;
        bus.stop   = 1'b0;
        bus.load   = 1'b0;
        bus.preset = 8'h00;

        // Asynchronous reset before any clock edge
        #2 reset = 1'b0;
        #1;
        chk("rst_count",   bus.count,   8'h00);
        chk("rst_running", bus.running, 1'b0);
        chk("rst_done",    bus.done,    1'b0);
        chk("rst_err",     bus.err,     1'b0);
        step(1);
        reset = 1'b1;
        step(1);

        // Load 12 and count down to 00
        bus.load = 1'b1; bus.preset = 8'h12;
        step(1);
        bus.load = 1'b0;
        chk("ld12_count",   bus.count,   8'h12);
        chk("ld12_running", bus.running, 1'b0);
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        chk("run12_running", bus.running, 1'b1);
        chk("run12_count",   bus.count,   8'h12);
        for (int i = 0; i < 12; i++) begin
            step(1);
            chk("cd_mid",  bus.count, (i == 0) ? 8'h12 : seq12[i-1]);
            step(1);
            chk("cd_count", bus.count, seq12[i]);
            chk("cd_done",  bus.done,  (seq12[i] == 8'h00) ? 1'b1 : 1'b0);
        end
        chk("cd_running_fell", bus.running, 1'b0);
        step(1);
        chk("done_single", bus.done,  1'b0);
        chk("done_hold",   bus.count, 8'h00);

        // Pause at 07, hold, resume
        bus.load = 1'b1; bus.preset = 8'h09;
        step(1);
        bus.load = 1'b0;
        chk("ld09_count", bus.count, 8'h09);
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        step(4);
        chk("at07", bus.count, 8'h07);
        bus.stop = 1'b1;
        step(1);
        chk("pause_running", bus.running, 1'b0);
        step(10);
        bus.stop = 1'b0;
        chk("pause_hold",  bus.count,   8'h07);
        chk("pause_run0",  bus.running, 1'b0);
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        chk("resume_running", bus.running, 1'b1);
        step(1);
        chk("resume_1clk", bus.count, 8'h07);
        step(1);
        chk("resume_2clk", bus.count, 8'h06);

        // Rejected loads and zero start
        bus.stop = 1'b1;
        step(1);
        bus.stop = 1'b0;
        bus.load = 1'b1; bus.preset = 8'h1A;
        step(1);
        bus.load = 1'b0;
        chk("bad1A_err",   bus.err,     1'b1);
        chk("bad1A_count", bus.count,   8'h06);
        chk("bad1A_run",   bus.running, 1'b0);
        step(1);
        chk("bad1A_errpulse", bus.err, 1'b0);
        bus.load = 1'b1; bus.preset = 8'hA1;
        step(1);
        bus.load = 1'b0;
        chk("badA1_err",   bus.err,   1'b1);
        chk("badA1_count", bus.count, 8'h06);
        bus.load = 1'b1; bus.preset = 8'h00;
        step(1);
        bus.load = 1'b0;
        chk("ld00_count", bus.count, 8'h00);
        chk("ld00_err",   bus.err,   1'b0);
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        chk("start0_err",  bus.err,     1'b1);
        chk("start0_run",  bus.running, 1'b0);
        step(1);
        chk("start0_errpulse", bus.err,     1'b0);
        chk("start0_idle",     bus.running, 1'b0);

        // Preset 03: wrap with auto reload, otherwise stop in DONE
        bus.load = 1'b1; bus.preset = 8'h03;
        step(1);
        bus.load = 1'b0;
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        step(2);
        chk("p3_02", bus.count, 8'h02);
        step(2);
        chk("p3_01", bus.count, 8'h01);
        step(2);
`ifdef BCD_TIMER_AUTO_RELOAD_EN
        chk("ar_wrap",    bus.count,   8'h03);
        chk("ar_done",    bus.done,    1'b1);
        chk("ar_running", bus.running, 1'b1);
        step(1);
        chk("ar_donepulse", bus.done, 1'b0);
        step(1);
        chk("ar_02", bus.count, 8'h02);
        step(4);
        chk("ar_wrap2", bus.count, 8'h03);
        chk("ar_done2", bus.done,  1'b1);
        chk("ar_err0",  bus.err,   1'b0);
`else
        chk("nr_00",      bus.count,   8'h00);
        chk("nr_done",    bus.done,    1'b1);
        chk("nr_running", bus.running, 1'b0);
        chk("nr_err0",    bus.err,     1'b0);
        step(5);
        chk("nr_hold",  bus.count, 8'h00);
        chk("nr_done0", bus.done,  1'b0);
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        chk("reload_count",   bus.count,   8'h03);
        chk("reload_running", bus.running, 1'b1);
`endif
        bus.stop = 1'b1;
        step(1);
        bus.stop = 1'b0;
        chk("stop_pause", bus.running, 1'b0);

        // Load beats start; reset mid-run aborts without done
        bus.load = 1'b1; bus.start = 1'b1; bus.preset = 8'h07;
        step(1);
        bus.load = 1'b0; bus.start = 1'b0;
        chk("prio_count",   bus.count,   8'h07);
        chk("prio_running", bus.running, 1'b0);
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        step(4);
        chk("mid_05", bus.count, 8'h05);
        #3 reset = 1'b0;
        #1;
        chk("mid_rst_count",   bus.count,   8'h00);
        chk("mid_rst_running", bus.running, 1'b0);
        chk("mid_rst_done",    bus.done,    1'b0);
        step(3);
        chk("mid_rst_nodone", bus.done,  1'b0);
        chk("mid_rst_hold",   bus.count, 8'h00);
        reset = 1'b1;
        step(1);
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        chk("post_rst_err", bus.err,     1'b1);
        chk("post_rst_run", bus.running, 1'b0);
        step(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
